// File: rtl/pixel_filter_pkg.sv
// Shared types and constants for the video filter colour-mapping path.
package pixel_filter_pkg;

  // Per-pixel colour mapping mode, sampled together with each accepted pixel
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_SEPIA  = 2'd2,
    MODE_INVERT = 2'd3
  } mode_e;

  // Coefficients are stored pre-scaled for this many fractional bits
  localparam int FRAC_W_DEF = 8;
  localparam int COEF_W     = 8;

  typedef logic [COEF_W-1:0] coef_t;
  // One output channel's weights, ordered (cR, cG, cB)
  typedef coef_t [0:2] coef_row_t;
  // Rows ordered (R', G', B')
  typedef coef_row_t [0:2] coef_mat_t;

  // Grayscale: every output channel carries the same luma value
  localparam coef_mat_t GRAY_COEF = {
    8'd77, 8'd150, 8'd29,
    8'd77, 8'd150, 8'd29,
    8'd77, 8'd150, 8'd29
  };

  // Sepia: row sums exceed 256, so R'/G' can overflow the channel range
  localparam coef_mat_t SEPIA_COEF = {
    8'd101, 8'd197, 8'd48,
    8'd89,  8'd176, 8'd43,
    8'd70,  8'd137, 8'd34
  };

  // Half an LSB of the fixed-point result, giving round-half-up on the shift
  function automatic int round_const(input int frac_w);
    return 32'sd1 <<< (frac_w - 1);
  endfunction

endpackage

// File: rtl/pixel_color_mapper_rgb_weighted_sum.sv
// One output channel's weighted sum: products in S1, rounded sum in S2.
module rgb_weighted_sum
  import pixel_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = FRAC_W_DEF,
  localparam int PROD_W = DATA_W + COEF_W,
  localparam int SUM_W  = DATA_W + COEF_W + 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic [3*DATA_W-1:0] i_pixel,
  input  coef_row_t           i_coef,
  output logic [SUM_W-1:0]    o_sum
);

  localparam logic [SUM_W-1:0] ROUND_W = SUM_W'(round_const(FRAC_W));

  logic [DATA_W-1:0] w_r;
  logic [DATA_W-1:0] w_g;
  logic [DATA_W-1:0] w_b;

  logic [PROD_W-1:0] r_prod_r;
  logic [PROD_W-1:0] r_prod_g;
  logic [PROD_W-1:0] r_prod_b;
  logic [SUM_W-1:0]  r_sum;

  assign w_r = i_pixel[3*DATA_W-1 -: DATA_W];
  assign w_g = i_pixel[2*DATA_W-1 -: DATA_W];
  assign w_b = i_pixel[DATA_W-1   -: DATA_W];

  // S1: register the three unsigned coefficient products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod_r <= '0;
      r_prod_g <= '0;
      r_prod_b <= '0;
    end else if (i_en) begin
      r_prod_r <= PROD_W'(i_coef[0]) * PROD_W'(w_r);
      r_prod_g <= PROD_W'(i_coef[1]) * PROD_W'(w_g);
      r_prod_b <= PROD_W'(i_coef[2]) * PROD_W'(w_b);
    end
  end

  // S2: register the sum plus rounding constant; two guard bits prevent overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= SUM_W'(r_prod_r) + SUM_W'(r_prod_g) + SUM_W'(r_prod_b) + ROUND_W;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/pixel_color_mapper.sv
// Per-pixel colour mapper: passthrough, grayscale, sepia or invert, with a
// three-stage stallable valid/ready pipeline at one pixel per cycle.
module pixel_color_mapper
  import pixel_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = FRAC_W_DEF,
  localparam int PIX_W = 3 * DATA_W,
  localparam int SUM_W = DATA_W + COEF_W + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last
);

  localparam logic [DATA_W-1:0] MAX_CH = '1;

  // Whole pipeline advances together; it only freezes when the output is held
  logic w_en;

  coef_mat_t              w_coef;
  logic [0:2][SUM_W-1:0]  w_sum;
  logic [0:2][DATA_W-1:0] w_sat;
  logic [PIX_W-1:0]       w_mapped;

  logic             r_s1_valid;
  logic             r_s2_valid;
  mode_e            r_s1_mode;
  mode_e            r_s2_mode;
  logic             r_s1_last;
  logic             r_s2_last;
  logic [PIX_W-1:0] r_s1_pixel;
  logic [PIX_W-1:0] r_s2_pixel;

  logic             r_out_valid;
  logic [PIX_W-1:0] r_out_pixel;
  logic             r_out_last;

  // Shift out the fractional bits and clip to the channel range
  function automatic logic [DATA_W-1:0] sat_shift(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] shifted;
    shifted = sum >> FRAC_W;
    if (shifted > SUM_W'(MAX_CH)) begin
      return MAX_CH;
    end else begin
      return shifted[DATA_W-1:0];
    end
  endfunction

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Choose the coefficient matrix from the incoming pixel's own mode
  always_comb begin
    w_coef = GRAY_COEF;
    if (mode_e'(in_mode) == MODE_SEPIA) begin
      w_coef = SEPIA_COEF;
    end else begin
      w_coef = GRAY_COEF;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    rgb_weighted_sum #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_sum (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_en),
      .i_pixel (in_pixel),
      .i_coef  (w_coef[gi]),
      .o_sum   (w_sum[gi])
    );
  end

  // Carry valid, mode, last and the raw pixel alongside the arithmetic stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_mode  <= MODE_PASS;
      r_s2_mode  <= MODE_PASS;
      r_s1_last  <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s1_pixel <= '0;
      r_s2_pixel <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= mode_e'(in_mode);
      r_s1_last  <= in_last;
      r_s1_pixel <= in_pixel;
      r_s2_valid <= r_s1_valid;
      r_s2_mode  <= r_s1_mode;
      r_s2_last  <= r_s1_last;
      r_s2_pixel <= r_s1_pixel;
    end
  end

  // S3 combinational: saturate each weighted channel and select by mode
  always_comb begin
    w_sat    = '0;
    w_mapped = r_s2_pixel;
    for (int k = 0; k < 3; k++) begin
      w_sat[k] = sat_shift(w_sum[k]);
    end
    case (r_s2_mode)
      MODE_PASS:   w_mapped = r_s2_pixel;
      MODE_INVERT: w_mapped = ~r_s2_pixel;
      MODE_GRAY:   w_mapped = {w_sat[0], w_sat[1], w_sat[2]};
      MODE_SEPIA:  w_mapped = {w_sat[0], w_sat[1], w_sat[2]};
      default:     w_mapped = r_s2_pixel;
    endcase
  end

  // S3 output register; data only moves when a real pixel advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_pixel <= w_mapped;
        r_out_last  <= r_s2_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_pixel_color_mapper.sv
// Scoreboard bench for pixel_color_mapper (DATA_W=8 main instance, DATA_W=10 spot checks).
module tb_pixel_color_mapper;

  typedef struct packed {
    logic [23:0] pix;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic [1:0]  in_mode;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pixel;
  logic        out_last;

  logic        in10_valid;
  logic        in10_ready;
  logic [29:0] in10_pixel;
  logic [1:0]  in10_mode;
  logic        in10_last;
  logic        out10_valid;
  logic [29:0] out10_pixel;
  logic        out10_last;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   bp_en    = 1'b0;
  exp_t sb_q[$];

  pixel_color_mapper #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_last  (out_last)
  );

  pixel_color_mapper #(.DATA_W(10)) dut10 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in10_valid),
    .in_ready  (in10_ready),
    .in_pixel  (in10_pixel),
    .in_mode   (in10_mode),
    .in_last   (in10_last),
    .out_valid (out10_valid),
    .out_ready (1'b1),
    .out_pixel (out10_pixel),
    .out_last  (out10_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: weighted sum, round half up by integer division, clip.
  function automatic logic [35:0] ref_map(input int mode, input int r, input int g,
                                          input int b, input int dw);
    int maxv;
    int acc;
    int ch[3];
    int o[3];
    int cf[3][3];
    maxv  = (1 << dw) - 1;
    ch[0] = r;
    ch[1] = g;
    ch[2] = b;
    if (mode == 2) begin
      cf[0] = '{101, 197, 48};
      cf[1] = '{89, 176, 43};
      cf[2] = '{70, 137, 34};
    end else begin
      for (int k = 0; k < 3; k++) cf[k] = '{77, 150, 29};
    end
    for (int k = 0; k < 3; k++) begin
      case (mode)
        0: o[k] = ch[k];
        3: o[k] = maxv - ch[k];
        default: begin
          acc  = cf[k][0] * r + cf[k][1] * g + cf[k][2] * b;
          o[k] = (acc + 128) / 256;
          if (o[k] > maxv) o[k] = maxv;
        end
      endcase
    end
    return (36'(o[0]) << (2 * dw)) | (36'(o[1]) << dw) | 36'(o[2]);
  endfunction

  function automatic logic [23:0] model8(input int mode, input logic [23:0] pix);
    logic [35:0] full;
    full = ref_map(mode, int'(pix[23:16]), int'(pix[15:8]), int'(pix[7:0]), 8);
    return full[23:0];
  endfunction

  // Offer one pixel until accepted; expected response is queued at acceptance
  task automatic send(input logic [23:0] pix, input logic [1:0] mode,
                      input logic last, input logic [23:0] exp);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pixel = pix;
    in_mode  = mode;
    in_last  = last;
    for (int w = 0; w < 1000 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{pix: exp, last: last});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 500 && sb_q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic send10(input logic [29:0] pix, input logic [1:0] mode, input logic [29:0] exp);
    in10_valid = 1'b1;
    in10_pixel = pix;
    in10_mode  = mode;
    @(posedge clk);
    #1;
    in10_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("w10_valid", 64'(out10_valid), 64'd1);
    check("w10_pixel", 64'(out10_pixel), 64'(exp));
  endtask

  // Randomise downstream readiness when back-pressure is enabled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop and compare on every output transfer, and check stall stability
  initial begin
    bit          held;
    logic [23:0] hold_pix;
    logic        hold_last;
    exp_t        e;
    held = 1'b0;
    hold_pix = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_pixel", 64'(out_pixel), 64'(hold_pix));
          check("stall_last", 64'(out_last), 64'(hold_last));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sb_q.size() == 0) begin
            check("unexpected_output", 64'(out_pixel), 64'hDEAD);
          end else begin
            e = sb_q.pop_front();
            check("out_pixel", 64'(out_pixel), 64'(e.pix));
            check("out_last", 64'(out_last), 64'(e.last));
          end
        end
        held      = out_valid && !out_ready;
        hold_pix  = out_pixel;
        hold_last = out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pix;
    logic [1:0]  mode;
    logic [35:0] full;
    logic [29:0] p10;
    int          out_before;
    int          lat;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_pixel   = '0;
    in_mode    = 2'd0;
    in_last    = 1'b0;
    in10_valid = 1'b0;
    in10_pixel = '0;
    in10_mode  = 2'd0;
    in10_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pixel", 64'(out_pixel), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);

    // Directed values, expected results worked out by hand
    send({8'd100, 8'd50, 8'd200}, 2'd1, 1'b0, {8'd82, 8'd82, 8'd82});
    send({8'd255, 8'd255, 8'd255}, 2'd1, 1'b0, {8'd255, 8'd255, 8'd255});
    send({8'd255, 8'd255, 8'd255}, 2'd2, 1'b1, {8'd255, 8'd255, 8'd240});
    send({8'd0, 8'd0, 8'd0}, 2'd2, 1'b0, {8'd0, 8'd0, 8'd0});
    send({8'd18, 8'd52, 8'd86}, 2'd0, 1'b0, {8'd18, 8'd52, 8'd86});
    send({8'd18, 8'd52, 8'd86}, 2'd3, 1'b1, {8'd237, 8'd203, 8'd169});
    drain("drain_directed");

    // Mode changes every cycle, back to back
    for (int i = 0; i < 16; i++) begin
      pix  = (i < 4) ? {8'd18, 8'd52, 8'd86} : 24'($urandom);
      mode = 2'(i);
      send(pix, mode, 1'(i % 5 == 0), model8(int'(mode), pix));
    end
    drain("drain_alternate");

    // 20-pixel line pair under random back-pressure
    bp_en = 1'b1;
    out_before = n_out;
    for (int i = 0; i < 20; i++) begin
      pix  = 24'($urandom);
      mode = 2'($urandom_range(0, 3));
      send(pix, mode, 1'(i == 9 || i == 19), model8(int'(mode), pix));
    end
    drain("drain_bp20");
    check("bp20_count", 64'(n_out - out_before), 64'd20);

    // Longer random stream with input bubbles and back-pressure
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      pix  = 24'($urandom);
      mode = 2'($urandom_range(0, 3));
      send(pix, mode, 1'($urandom_range(0, 1)), model8(int'(mode), pix));
    end
    drain("drain_random");

    // Asynchronous reset with two pixels in flight
    bp_en = 1'b0;
    idle(2);
    send({8'd10, 8'd20, 8'd30}, 2'd3, 1'b1, {8'd245, 8'd235, 8'd225});
    send({8'd40, 8'd50, 8'd60}, 2'd1, 1'b1, model8(1, {8'd40, 8'd50, 8'd60}));
    #1;
    reset = 1'b1;
    sb_q.delete();
    out_before = n_out;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_pixel", 64'(out_pixel), 64'd0);
    check("midrst_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    idle(6);
    check("midrst_no_stale", 64'(n_out - out_before), 64'd0);
    send({8'd18, 8'd52, 8'd86}, 2'd0, 1'b0, {8'd18, 8'd52, 8'd86});
    lat = 1;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    drain("drain_reset");

    // DATA_W=10 instance
    @(posedge clk);
    #1;
    send10({10'd1023, 10'd0, 10'd0}, 2'd1, {10'd308, 10'd308, 10'd308});
    for (int i = 0; i < 8; i++) begin
      p10  = 30'($urandom);
      mode = 2'(i);
      full = ref_map(int'(mode), int'(p10[29:20]), int'(p10[19:10]), int'(p10[9:0]), 10);
      send10(p10, mode, full[29:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
